// File: rtl/dmem_pkg.sv
// Shared encodings for the sized-access data memory: access sizes and clear FSM states.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_word_array.sv
// Word-organised storage with four byte lanes, per-lane write enables and asynchronous read.
module dmem_word_array #(
  parameter int unsigned WORDS = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // we[3] is lane bits [31:24], i.e. the lowest byte address of the word.
  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < 4; l++) begin
      if (we[l]) mem[waddr][8*l +: 8] <= wdata[8*l +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_sized_access.sv
// Big-endian data memory with byte/half/word loads and stores, post-reset clear and fault capture.
module dmem_sized_access
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES    = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size_in,
  input  logic        unsigned_in,
  input  logic [31:0] address_in,
  input  logic [31:0] write_data_in,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        misaligned,
  output logic        out_of_range,
  output logic        fault_valid,
  output logic [31:0] fault_addr,
  output logic        fault_is_write
);

  localparam int unsigned WORDS = DEPTH_BYTES / 4;
  localparam int unsigned AW    = $clog2(WORDS);

  size_e         size;
  state_e        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic [31:0]   offset;
  logic [1:0]    lane;
  logic [AW-1:0] word_idx;
  logic          in_range, mis_raw, access, legal, store_en, clr_en;
  logic [31:0]   rdata, load_val, st_wdata, arr_wdata;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [3:0]    st_we, arr_we;
  logic [AW-1:0] arr_waddr;

  assign size     = size_e'(size_in);
  assign offset   = address_in - BASE_ADDR;
  assign lane     = offset[1:0];
  assign word_idx = offset[AW+1:2];
  assign in_range = offset < DEPTH_BYTES;

  always_comb begin
    mis_raw = 1'b0;
    unique case (size)
      SZ_BYTE: mis_raw = 1'b0;
      SZ_HALF: mis_raw = lane[0];
      SZ_WORD: mis_raw = |lane;
      default: mis_raw = 1'b1;
    endcase
  end

  assign access       = (mem_read | mem_write) & ~busy;
  assign misaligned   = access & mis_raw;
  assign out_of_range = access & ~in_range;
  assign legal        = access & ~mis_raw & in_range;
  assign store_en     = mem_write & legal & ~reset;

  always_comb begin
    byte_sel = rdata[31:24];
    unique case (lane)
      2'd0: byte_sel = rdata[31:24];
      2'd1: byte_sel = rdata[23:16];
      2'd2: byte_sel = rdata[15:8];
      2'd3: byte_sel = rdata[7:0];
    endcase
    half_sel = lane[1] ? rdata[15:0] : rdata[31:16];
    load_val = rdata;
    unique case (size)
      SZ_BYTE: load_val = unsigned_in ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_val = unsigned_in ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_val = rdata;
    endcase
  end

  assign data_out = (mem_read & legal) ? load_val : '0;

  always_comb begin
    st_we    = '0;
    st_wdata = write_data_in;
    unique case (size)
      SZ_BYTE: begin
        st_we    = 4'b1000 >> lane;
        st_wdata = {4{write_data_in[7:0]}};
      end
      SZ_HALF: begin
        st_we    = lane[1] ? 4'b0011 : 4'b1100;
        st_wdata = {2{write_data_in[15:0]}};
      end
      SZ_WORD: st_we = 4'b1111;
      default: st_we = '0;
    endcase
  end

  // Clear FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == ST_CLEAR) begin
      cnt_nx = cnt + 1'b1;
      if (cnt == AW'(WORDS - 1)) state_nx = ST_IDLE;
    end
  end

  always_comb begin
    busy   = (state == ST_CLEAR);
    clr_en = busy & ~reset;
  end

  // Loads and stores are ignored while busy, so the clear owns the write port exclusively.
  assign arr_we    = clr_en ? 4'b1111 : (store_en ? st_we : 4'b0000);
  assign arr_waddr = busy ? cnt : word_idx;
  assign arr_wdata = busy ? '0 : st_wdata;

  dmem_word_array #(.WORDS(WORDS), .AW(AW)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (word_idx),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_valid    <= 1'b0;
      fault_addr     <= '0;
      fault_is_write <= 1'b0;
    end else if (!fault_valid && (misaligned || out_of_range)) begin
      fault_valid    <= 1'b1;
      fault_addr     <= address_in;
      fault_is_write <= mem_write;
    end
  end

endmodule

// File: tb/tb_dmem_sized_access.sv
// Self-checking bench for dmem_sized_access against a byte-array reference model.
module tb_dmem_sized_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, unsigned_in;
  logic [1:0]  size_in;
  logic [31:0] address_in, write_data_in;
  logic [31:0] data_out, fault_addr;
  logic        busy, misaligned, out_of_range, fault_valid, fault_is_write;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mdl_mem [1024];
  logic        mdl_fv;
  logic [31:0] mdl_fa;
  logic        mdl_fw;

  always #5 clk = ~clk;

  dmem_sized_access #(.DEPTH_BYTES(1024), .BASE_ADDR(32'h0), .CLEAR_ON_RESET(1'b1)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .size_in        (size_in),
    .unsigned_in    (unsigned_in),
    .address_in     (address_in),
    .write_data_in  (write_data_in),
    .data_out       (data_out),
    .busy           (busy),
    .misaligned     (misaligned),
    .out_of_range   (out_of_range),
    .fault_valid    (fault_valid),
    .fault_addr     (fault_addr),
    .fault_is_write (fault_is_write)
  );

  function automatic logic m_oor(input logic [31:0] a);
    return a >= 32'd1024;
  endfunction

  function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic un, input logic [31:0] a);
    int unsigned i;
    logic [7:0]  b;
    logic [15:0] h;
    i = a[9:0];
    case (sz)
      2'd0: begin
        b = mdl_mem[i];
        return un ? {24'h0, b} : {{24{b[7]}}, b};
      end
      2'd1: begin
        h = {mdl_mem[i], mdl_mem[i+1]};
        return un ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: return {mdl_mem[i], mdl_mem[i+1], mdl_mem[i+2], mdl_mem[i+3]};
    endcase
  endfunction

  task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int unsigned i;
    i = a[9:0];
    case (sz)
      2'd0: mdl_mem[i] = d[7:0];
      2'd1: begin
        mdl_mem[i] = d[15:8]; mdl_mem[i+1] = d[7:0];
      end
      default: begin
        mdl_mem[i] = d[31:24]; mdl_mem[i+1] = d[23:16];
        mdl_mem[i+2] = d[15:8]; mdl_mem[i+3] = d[7:0];
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_read = rd; mem_write = wr; size_in = sz; unsigned_in = un;
    address_in = a; write_data_in = wd;
    #1;
  endtask

  task automatic idle();
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
  endtask

  // Applies n reset cycles; model memory becomes zero once the clear completes.
  task automatic apply_reset(input int n);
    idle();
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
    for (int i = 0; i < 1024; i++) mdl_mem[i] = 8'h00;
    mdl_fv = 1'b0; mdl_fa = '0; mdl_fw = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 2000) begin
      cycles++;
      tick();
    end
    if (cycles >= 2000) begin
      checks++; errors++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, cycles);
    end
  endtask

  task automatic test_reset();
    int c;
    apply_reset(1);
    checks++;
    if (fault_valid !== 1'b0 || fault_addr !== 32'h0 || fault_is_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_fault: got v=%b a=%h w=%b, required 0/0/0", fault_valid, fault_addr, fault_is_write);
    end
    wait_idle(c);
    checks++;
    if (c !== 256) begin
      errors++; $display("FAIL busy_len: got %0d cycles, required 256", c);
    end
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);
    checks++;
    if (data_out !== 32'h0) begin
      errors++; $display("FAIL lw_3fc: got %h, required 00000000", data_out);
    end
    idle();
  endtask

  task automatic test_store_load();
    logic [31:0] e;
    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
    m_store(2'd2, 32'h10, 32'h11223344);
    tick();
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
    checks++;
    if (data_out !== 32'h00000011) begin errors++; $display("FAIL lb_10: got %h, required 00000011", data_out); end
    drive(1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    checks++;
    if (data_out !== 32'h00000044) begin errors++; $display("FAIL lbu_13: got %h, required 00000044", data_out); end
    drive(1'b1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    checks++;
    if (data_out !== 32'h00003344) begin errors++; $display("FAIL lh_12: got %h, required 00003344", data_out); end
    drive(1'b1, 1'b0, 2'd2, 1'b1, 32'h10, 32'h0);
    e = m_load(2'd2, 1'b1, 32'h10);
    checks++;
    if (data_out !== 32'h11223344 || data_out !== e) begin errors++; $display("FAIL lw_10: got %h, required 11223344", data_out); end
    idle();
  endtask

  task automatic test_sub_word();
    drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h000000FF);
    m_store(2'd0, 32'h21, 32'hFF);
    tick();
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    checks++;
    if (data_out !== 32'h00FF0000) begin errors++; $display("FAIL lw_20: got %h, required 00FF0000", data_out); end
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h21, 32'h0);
    checks++;
    if (data_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL lb_21: got %h, required FFFFFFFF", data_out); end
    drive(1'b1, 1'b0, 2'd0, 1'b1, 32'h21, 32'h0);
    checks++;
    if (data_out !== 32'h000000FF) begin errors++; $display("FAIL lbu_21: got %h, required 000000FF", data_out); end
    idle();
  endtask

  task automatic test_fault();
    int c;
    apply_reset(1);
    wait_idle(c);
    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h102, 32'hCAFEF00D);
    checks++;
    if (misaligned !== 1'b1 || out_of_range !== 1'b0) begin
      errors++; $display("FAIL sw_102_flags: got mis=%b oor=%b, required 1/0", misaligned, out_of_range);
    end
    tick();
    checks++;
    if (fault_valid !== 1'b1 || fault_addr !== 32'h102 || fault_is_write !== 1'b1) begin
      errors++;
      $display("FAIL fault_rec: got v=%b a=%h w=%b, required 1/00000102/1", fault_valid, fault_addr, fault_is_write);
    end
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL mem_unchanged: got %h, required 00000000", data_out); end
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL mem_unchanged2: got %h, required 00000000", data_out); end
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h500, 32'h0);
    checks++;
    if (out_of_range !== 1'b1 || misaligned !== 1'b0 || data_out !== 32'h0) begin
      errors++; $display("FAIL lw_500: got oor=%b mis=%b d=%h, required 1/0/0", out_of_range, misaligned, data_out);
    end
    tick();
    checks++;
    if (fault_addr !== 32'h102 || fault_is_write !== 1'b1 || fault_valid !== 1'b1) begin
      errors++; $display("FAIL fault_sticky: got a=%h w=%b, required 00000102/1", fault_addr, fault_is_write);
    end
    idle();
  endtask

  task automatic test_busy_write();
    int c;
    apply_reset(1);
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF);
    checks++;
    if (busy !== 1'b1 || misaligned !== 1'b0 || out_of_range !== 1'b0 || data_out !== 32'h0) begin
      errors++;
      $display("FAIL busy_sw: got busy=%b mis=%b oor=%b d=%h, required 1/0/0/0", busy, misaligned, out_of_range, data_out);
    end
    repeat (50) tick();
    drive(1'b1, 1'b1, 2'd3, 1'b0, 32'h800, 32'hDEADBEEF);
    checks++;
    if (misaligned !== 1'b0 || out_of_range !== 1'b0) begin
      errors++; $display("FAIL busy_flags: got mis=%b oor=%b, required 0/0", misaligned, out_of_range);
    end
    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF);
    wait_idle(c);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    checks++;
    if (data_out !== 32'h0 || fault_valid !== 1'b0) begin
      errors++; $display("FAIL busy_ignored: got d=%h fv=%b, required 00000000/0", data_out, fault_valid);
    end
    idle();
  endtask

  task automatic test_reset_restart();
    int c;
    bit  dropped;
    apply_reset(1);
    dropped = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy !== 1'b1) dropped = 1;
      tick();
    end
    reset = 1'b1;
    tick();
    if (busy !== 1'b1) dropped = 1;
    reset = 1'b0;
    checks++;
    if (dropped) begin errors++; $display("FAIL restart_busy: busy dropped, required 1 throughout"); end
    wait_idle(c);
    checks++;
    if (c !== 256) begin errors++; $display("FAIL restart_len: got %0d cycles, required 256", c); end
  endtask

  task automatic test_random();
    logic        rd, wr, un;
    logic [1:0]  sz;
    logic [31:0] a, wd, e_d;
    logic        e_mis, e_oor;
    for (int n = 0; n < 400; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      un = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      if (sz == 2'd1 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
      if (sz == 2'd2 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      wd = $urandom;
      drive(rd, wr, sz, un, a, wd);
      e_mis = (rd | wr) & m_mis(sz, a);
      e_oor = (rd | wr) & m_oor(a);
      e_d   = (rd && !m_mis(sz, a) && !m_oor(a)) ? m_load(sz, un, a) : 32'h0;
      checks++;
      if (data_out !== e_d || misaligned !== e_mis || out_of_range !== e_oor) begin
        errors++;
        $display("FAIL rand_%0d: rd=%b wr=%b sz=%0d a=%h got d=%h mis=%b oor=%b, required d=%h mis=%b oor=%b",
                 n, rd, wr, sz, a, data_out, misaligned, out_of_range, e_d, e_mis, e_oor);
      end
      if (wr && !m_mis(sz, a) && !m_oor(a)) m_store(sz, a, wd);
      if (!mdl_fv && (e_mis || e_oor)) begin
        mdl_fv = 1'b1; mdl_fa = a; mdl_fw = wr;
      end
      tick();
    end
    idle();
    checks++;
    if (fault_valid !== mdl_fv || fault_addr !== mdl_fa || fault_is_write !== mdl_fw) begin
      errors++;
      $display("FAIL rand_fault: got v=%b a=%h w=%b, required v=%b a=%h w=%b",
               fault_valid, fault_addr, fault_is_write, mdl_fv, mdl_fa, mdl_fw);
    end
    for (int w = 0; w < 1024; w += 4) begin
      drive(1'b1, 1'b0, 2'd2, 1'b0, 32'(w), 32'h0);
      e_d = m_load(2'd2, 1'b0, 32'(w));
      checks++;
      if (data_out !== e_d) begin
        errors++; $display("FAIL sweep_%h: got %h, required %h", w, data_out, e_d);
      end
    end
    idle();
  endtask

  initial begin
    reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size_in = 2'd0;
    unsigned_in = 1'b0; address_in = '0; write_data_in = '0;
    tick();
    test_reset();
    test_store_load();
    test_sub_word();
    test_fault();
    test_busy_write();
    test_reset_restart();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
